if_id_queue: RTL and testbench

Fetch-to-decode decoupling queue that sits directly downstream of the instruction fetch unit in the 5-stage RISC-V pipeline. It captures each {PC, instruction} pair the fetch unit presents, buffers up to DEPTH entries, and hands them to decode with a valid/ready handshake. It drives the fetch unit's stall input when full, discards wrong-path entries on a branch/jump flush, and presents a NOP to decode whenever it is empty.

---
 rtl/if_id_queue.sv | 84 ++++++++
 tb/tb_if_id_queue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: buffers {PC, instruction} pairs from fetch,
// back-pressures fetch when full, drops everything on a redirect, shows a NOP when empty.
module if_id_queue #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       flush,
  output logic                       fetch_stall,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            full, empty, enq, deq;
  entry_t          head;

  // Handshake decode and pointer/occupancy next state; flush wins over enq/deq.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    enq      = in_valid && !full && !flush;
    deq      = !empty && out_ready && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (enq && !reset) begin
      mem[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
    end
  end

  always_comb begin
    head        = mem[rd_ptr_q];
    out_valid   = !empty;
    out_pc      = empty ? 32'h0 : head.pc;
    out_instr   = empty ? NOP_INSTR : head.instr;
    fetch_stall = full;
    count       = count_q;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: fetch-unit model feeding a scoreboard FIFO,
// directed scenarios followed by a randomized back-pressure/flush run.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          flush;
  logic          fetch_stall;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic [CW-1:0] count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] fpc;
  int          n_checks = 0;
  int          n_fail   = 0;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .flush       (flush),
    .fetch_stall (fetch_stall),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready),
    .count       (count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[23:0], 8'h33};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare all DUT outputs against the scoreboard head.
  task automatic check_outputs();
    logic        ev;
    logic [31:0] epc, ein;
    ev  = (sb.size() != 0);
    epc = ev ? sb[0].pc : 32'h0;
    ein = ev ? sb[0].instr : NOP;
    check_eq("out_valid", 64'(out_valid), 64'(ev));
    check_eq("out_pc", 64'(out_pc), 64'(epc));
    check_eq("out_instr", 64'(out_instr), 64'(ein));
    check_eq("count", 64'(count), 64'(sb.size()));
    check_eq("fetch_stall", 64'(fetch_stall), 64'(sb.size() == DEPTH));
    check_eq("count_le_depth", 64'(count <= CW'(DEPTH)), 64'd1);
  endtask

  // One clock: check state, present fetch pair, update models, advance to next negedge.
  task automatic cycle(input logic rst, input logic fl, input logic v, input logic rdy,
                       input logic [31:0] target);
    logic full;
    ent_t e;
    check_outputs();
    reset     = rst;
    flush     = fl;
    in_valid  = v;
    out_ready = rdy;
    in_pc     = fpc;
    in_instr  = instr_of(fpc);
    full      = (sb.size() == DEPTH);
    if (rst || fl) begin
      sb.delete();
    end else begin
      if (sb.size() > 0 && rdy) void'(sb.pop_front());
      if (v && !full) begin
        e.pc    = fpc;
        e.instr = instr_of(fpc);
        sb.push_back(e);
      end
    end
    if (rst)           fpc = 32'h0;
    else if (fl)       fpc = target;
    else if (v && !full) fpc = fpc + 32'd4;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; fpc = '0;
    @(negedge clock);
    @(negedge clock);
    sb.delete();

    // Reset values
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_pc", 64'(out_pc), 64'd0);
    check_eq("rst_instr", 64'(out_instr), 64'h13);
    check_eq("rst_stall", 64'(fetch_stall), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);

    // Streaming with decode always ready
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    check_eq("stream_first_pc", 64'(out_pc), 64'h0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    check_eq("stream_count", 64'(count), 64'd1);
    check_eq("stream_pc", 64'(out_pc), 64'h18);

    // Back-pressure until full, then release
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("bp_stall", 64'(fetch_stall), 64'd1);
    check_eq("bp_count", 64'(count), 64'd2);
    check_eq("bp_head", 64'(out_pc), 64'h0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);

    // Flush while full with 0x10 presented; target path starts at 0x40
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("pre_flush_count", 64'(count), 64'd2);
    fpc = 32'h10;
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    check_eq("flush_instr", 64'(out_instr), 64'h13);
    check_eq("flush_pc", 64'(out_pc), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    check_eq("target_pc", 64'(out_pc), 64'h40);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);

    // Sustained enq+deq at count 1 across pointer wrap
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 10; i++) begin
      check_eq("wrap_count", 64'(count), 64'd1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    end

    // Flush and reset together, then random traffic with occasional redirects
    fpc = 32'h100;
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 200; i++) begin
      logic fl;
      fl = ($urandom_range(15) == 0);
      cycle(1'b0, fl, 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
            {18'h0, 12'($urandom_range(4095)), 2'b00});
    end

    // Reset while full
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("full_before_reset", 64'(count), 64'd2);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    check_eq("rst_full_count", 64'(count), 64'd0);
    check_eq("rst_full_stall", 64'(fetch_stall), 64'd0);
    check_eq("rst_full_instr", 64'(out_instr), 64'h13);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
